// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: folds the timer, DMA, flash and external
// interrupt sources onto the single CPU interrupt, with a claim/EOI handshake.
module irq_ctrl #(
  parameter int                NUM_IRQ   = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 24,
  parameter int                CMD_W     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'h00_0F00
) (
  input  logic               clk0,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [CMD_W-1:0]   host_cmd,
  input  logic [DATA_W-1:0]  host_datain,
  output logic [DATA_W-1:0]  host_dataout,
  output logic               host_ack,
  output logic               cpu_irq,
  output logic [2:0]         irq_id
);

  // state     | meaning
  // S_IDLE    | no request to the CPU; arbitrate eligible sources
  // S_ASSERT  | cpu_irq high for irq_id; tracks a higher-priority newcomer
  // S_SERVICE | claimed; irq_id held until an EOI write
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [CMD_W-1:0] CMD_RD = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WR = CMD_W'(2);

  localparam logic [2:0] REG_RAW   = 3'd0;
  localparam logic [2:0] REG_PEND  = 3'd1;
  localparam logic [2:0] REG_MASK  = 3'd2;
  localparam logic [2:0] REG_EDGE  = 3'd3;
  localparam logic [2:0] REG_CLAIM = 3'd4;
  localparam logic [2:0] REG_EOI   = 3'd5;

  state_t               r_state;
  logic [NUM_IRQ-1:0]   r_mask;
  logic [NUM_IRQ-1:0]   r_edge;
  logic [NUM_IRQ-1:0]   r_pend;
  logic [NUM_IRQ-1:0]   r_prev_src;
  logic [2:0]           r_irq_id;
  logic                 r_cpu_irq;
  logic                 r_ack;
  logic [DATA_W-1:0]    r_dout;

  logic                 w_hit;
  logic                 w_rd;
  logic                 w_wr;
  logic [2:0]           w_sel;
  logic [NUM_IRQ-1:0]   w_wdata;
  logic [NUM_IRQ-1:0]   w_elig;
  logic [2:0]           w_winner;
  logic                 w_any;
  logic [NUM_IRQ-1:0]   w_id_oh;
  logic                 w_cur_elig;
  logic                 w_claim;
  logic                 w_eoi;
  logic [NUM_IRQ-1:0]   w_rise;
  logic [NUM_IRQ-1:0]   w_w1c;
  logic [NUM_IRQ-1:0]   w_claim_clr;
  logic [NUM_IRQ-1:0]   w_pend_nxt;
  logic [DATA_W-1:0]    w_claim_word;
  logic [DATA_W-1:0]    w_rdata;
  logic                 w_unused;

  assign w_hit   = (host_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign w_rd    = w_hit && (host_cmd == CMD_RD);
  assign w_wr    = w_hit && (host_cmd == CMD_WR);
  assign w_sel   = host_addr[2:0];
  assign w_wdata = host_datain[NUM_IRQ-1:0];

  assign w_unused = &{1'b0, host_addr[3], host_datain[DATA_W-1:NUM_IRQ]};

  assign w_elig = r_pend & r_mask;
  assign w_any  = |w_elig;

  // Lowest set index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    w_winner = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winner = 3'(i);
    end
  end

  always_comb begin
    w_id_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_id_oh[i] = (r_irq_id == 3'(i));
    end
  end

  assign w_cur_elig = |(w_elig & w_id_oh);
  assign w_claim    = w_rd && (w_sel == REG_CLAIM) && (r_state == S_ASSERT);
  assign w_eoi      = w_wr && (w_sel == REG_EOI) && (r_state == S_SERVICE);

  // Edge bits: clears (W1C or claim) lose to a same-cycle rising edge.
  // Level bits simply track the source.
  assign w_rise      = irq_src & ~r_prev_src;
  assign w_w1c       = (w_wr && (w_sel == REG_PEND)) ? w_wdata : '0;
  assign w_claim_clr = w_claim ? (w_id_oh & r_edge) : '0;
  assign w_pend_nxt  = (r_edge & ((r_pend & ~w_w1c & ~w_claim_clr) | w_rise))
                     | (~r_edge & irq_src);

  always_comb begin
    w_claim_word           = '0;
    w_claim_word[DATA_W-1] = (r_state == S_ASSERT);
    w_claim_word[2:0]      = r_irq_id;
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_RAW:   w_rdata = DATA_W'(irq_src);
      REG_PEND:  w_rdata = DATA_W'(r_pend);
      REG_MASK:  w_rdata = DATA_W'(r_mask);
      REG_EDGE:  w_rdata = DATA_W'(r_edge);
      REG_CLAIM: w_rdata = w_claim_word;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!reset) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_pend     <= '0;
      r_prev_src <= '0;
      r_ack      <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_prev_src <= irq_src;
      r_pend     <= w_pend_nxt;
      r_ack      <= w_rd | w_wr;
      if (w_rd) r_dout <= w_rdata;
      if (w_wr && (w_sel == REG_MASK)) r_mask <= w_wdata;
      if (w_wr && (w_sel == REG_EDGE)) r_edge <= w_wdata;
    end
  end

  always_ff @(posedge clk0) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_irq_id  <= 3'd0;
      r_cpu_irq <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cpu_irq <= 1'b0;
          if (w_any) begin
            r_irq_id  <= w_winner;
            r_cpu_irq <= 1'b1;
            r_state   <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (w_claim) begin
            r_cpu_irq <= 1'b0;
            r_state   <= S_SERVICE;
          end else if (!w_cur_elig) begin
            r_cpu_irq <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            // Current id is still eligible, so the winner is it or higher priority.
            r_irq_id  <= w_winner;
            r_cpu_irq <= 1'b1;
          end
        end
        S_SERVICE: begin
          r_cpu_irq <= 1'b0;
          if (w_eoi) r_state <= S_IDLE;
        end
        default: begin
          r_cpu_irq <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign host_dataout = r_dout;
  assign host_ack     = r_ack;
  assign cpu_irq      = r_cpu_irq;
  assign irq_id       = r_irq_id;

endmodule
